alu_seq_nbit: RTL and testbench
===============================

ALU_SEQ_NBIT -- requirements
Module: alu_seq_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 3 bits: operation select, sampled with start.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled with start.
REQ-007 The block SHALL have port result, output, WIDTH bits: registered result, or low product half for MUL.
REQ-008 The block SHALL have port result_hi, output, WIDTH bits: high product half for MUL, 0 for all other ops.
REQ-009 The block SHALL have ports cout, overflow and zero, output, 1 bit each: registered flags.
REQ-010 The block SHALL have ports busy and done, output, 1 bit each: busy is high while not IDLE; done is a one-cycle completion pulse.

Function
REQ-011 The op encoding SHALL be: 000 AND, 001 OR, 010 ADD, 011 MUL (unsigned), 100 NOR, 101 XOR, 110 SUB, 111 SLT (signed).
REQ-012 The FSM SHALL have states IDLE, MULT and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start=1 and op not MUL, the block SHALL register all outputs at that edge and enter DONE, giving a latency of 1 cycle.
REQ-014 In IDLE with start=1 and op=MUL, the block SHALL latch a and b, clear the product accumulator, load the counter with WIDTH and enter MULT.
REQ-015 MULT SHALL perform one shift-add step per cycle over the 2*WIDTH-bit accumulator, and leave for DONE on the edge where the counter reaches 0, after exactly WIDTH cycles in MULT.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Any start while in MULT or DONE SHALL be ignored and not queued; a new request is accepted only in IDLE.
REQ-018 ADD SHALL compute a+b mod 2^WIDTH, with cout the carry out of the MSB and overflow the signed overflow.
REQ-019 SUB SHALL compute a+~b+1, with cout the carry out (1 means no borrow) and overflow the signed overflow.
REQ-020 SLT SHALL set result to 1 when the SUB sign XOR the SUB overflow is 1, else 0, and SHALL clear cout and overflow.
REQ-021 Logic ops and MUL SHALL drive cout=0 and overflow=0.
REQ-022 For every op, zero SHALL be 1 exactly when result is all zeros; result_hi does not affect zero.
REQ-023 All outputs except busy and done SHALL hold their values from completion until the next completion.
REQ-024 MULT SHALL leave result, result_hi and the flags unchanged until the edge that enters DONE.

Reset
REQ-025 On reset, the block SHALL force state IDLE and clear result, result_hi, cout, overflow, zero, busy, done, the counter and the accumulator to 0.
REQ-026 Reset SHALL take priority over start in the same cycle.
REQ-027 Reset asserted during MULT or DONE SHALL abort the operation, produce no done pulse and discard any partial product.

Verification (bench with WIDTH=8)
REQ-028 The bench SHALL check ADD: a=0xFF, b=0x01 -> one cycle later done=1, result=0x00, cout=1, overflow=0, zero=1.
REQ-029 The bench SHALL check signed overflow: ADD a=0x7F, b=0x01 gives result=0x80, overflow=1, cout=0; then SLT a=0x80, b=0x01 gives result=0x01.
REQ-030 The bench SHALL check MUL: a=0xFF, b=0xFF -> busy for 9 cycles, done on the 9th cycle after the start edge, result=0x01, result_hi=0xFE, zero=0.
REQ-031 The bench SHALL check start ignored: start=1 with op=ADD during MULT leaves the MUL result unchanged and gives exactly one done pulse.
REQ-032 The bench SHALL check reset mid-MUL: reset at the 4th MULT cycle -> next cycle busy=0, done=0, all outputs 0, no later done pulse.
REQ-033 The bench SHALL check back-to-back ops: start held high with alternating ops -> one request accepted every 2 cycles for single-cycle ops, and each result matches a reference model.

Source files
------------

// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: single-cycle logic/arith ops plus a WIDTH-cycle shift-add
// unsigned multiplier producing a 2*WIDTH-bit product.
module alu_seq_nbit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     add_c, sub_c, mul_sum_c;
  logic               add_ovf_c, sub_ovf_c;
  logic [2*WIDTH-1:0] acc_step_c;
  logic               load_c;
  logic [WIDTH-1:0]   res_c, res_hi_c;
  logic               cout_c, ovf_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (op == OP_MUL) ? MULT : DONE;
      MULT:    if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Arithmetic datapath and the values loaded into the result registers
  always_comb begin
    add_c     = {1'b0, a} + {1'b0, b};
    sub_c     = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);
    add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (add_c[WIDTH-1] != a[WIDTH-1]);
    sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (sub_c[WIDTH-1] != a[WIDTH-1]);

    // One right-shifting shift-add step; carry of the upper-half add shifts in
    mul_sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mul_b[0] ? mul_a : '0)};
    acc_step_c = {mul_sum_c, acc[WIDTH-1:1]};

    load_c   = 1'b0;
    res_c    = '0;
    res_hi_c = '0;
    cout_c   = 1'b0;
    ovf_c    = 1'b0;

    if (state == IDLE && start && op != OP_MUL) begin
      load_c = 1'b1;
      case (op)
        OP_AND: res_c = a & b;
        OP_OR:  res_c = a | b;
        OP_ADD: begin
          res_c  = add_c[WIDTH-1:0];
          cout_c = add_c[WIDTH];
          ovf_c  = add_ovf_c;
        end
        OP_NOR: res_c = ~(a | b);
        OP_XOR: res_c = a ^ b;
        OP_SUB: begin
          res_c  = sub_c[WIDTH-1:0];
          cout_c = sub_c[WIDTH];
          ovf_c  = sub_ovf_c;
        end
        OP_SLT: res_c = WIDTH'(sub_c[WIDTH-1] ^ sub_ovf_c);
        default: res_c = '0;
      endcase
    end else if (state == MULT && cnt == CW'(1)) begin
      load_c   = 1'b1;
      res_c    = acc_step_c[WIDTH-1:0];
      res_hi_c = acc_step_c[2*WIDTH-1:WIDTH];
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (state == IDLE && start && op == OP_MUL) begin
        mul_a <= a;
        mul_b <= b;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
      end else if (state == MULT) begin
        acc   <= acc_step_c;
        mul_b <= mul_b >> 1;
        cnt   <= cnt - CW'(1);
      end
      if (load_c) begin
        result    <= res_c;
        result_hi <= res_hi_c;
        cout      <= cout_c;
        overflow  <= ovf_c;
        zero      <= (res_c == '0);
      end
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Randomized and directed self-checking bench for alu_seq_nbit at WIDTH=8.
module tb_alu_seq_nbit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         cout, overflow, zero, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .cout(cout),
    .overflow(overflow), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from plain integer arithmetic
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] rh,
                                output logic c, output logic v, output logic z);
    int ux, uy, sx, sy, s, ss;
    ux = int'(x); uy = int'(y);
    sx = $signed(x); sy = $signed(y);
    r = '0; rh = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        s = ux + uy; ss = sx + sy;
        r = W'(s); c = (s > 255); v = (ss > 127 || ss < -128);
      end
      3'd3: begin
        s = ux * uy;
        r = W'(s); rh = W'(s >> 8);
      end
      3'd4: r = ~(x | y);
      3'd5: r = x ^ y;
      3'd6: begin
        s = ux - uy; ss = sx - sy;
        r = W'(s); c = (ux >= uy); v = (ss > 127 || ss < -128);
      end
      default: r = (sx < sy) ? W'(1) : W'(0);
    endcase
    z = (r == '0);
  endfunction

  task automatic check_outputs(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r, rh;
    logic c, v, z;
    model(o, x, y, r, rh, c, v, z);
    check({tag, ".result"},    64'(result),    64'(r));
    check({tag, ".result_hi"}, 64'(result_hi), 64'(rh));
    check({tag, ".cout"},      64'(cout),      64'(c));
    check({tag, ".overflow"},  64'(overflow),  64'(v));
    check({tag, ".zero"},      64'(zero),      64'(z));
  endtask

  // Issue one op from IDLE, wait for done, check latency, busy and outputs
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    int busy_bad;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 1; busy_bad = 0;
    while (!done && lat < 20) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      lat++;
    end
    check({tag, ".latency"}, 64'(lat), (o == 3'd3) ? 64'd9 : 64'd1);
    check({tag, ".busy_run"}, 64'(busy_bad), 64'd0);
    check({tag, ".busy_done"}, 64'(busy), 64'd1);
    check_outputs(tag, o, x, y);
    tick();
    check({tag, ".done_clear"}, 64'(done), 64'd0);
    check({tag, ".idle"}, 64'(busy), 64'd0);
    check_outputs({tag, ".hold"}, o, x, y);
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int pulses;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    tick(); tick();
    check("rst.result", 64'(result), 64'd0);
    check("rst.result_hi", 64'(result_hi), 64'd0);
    check("rst.flags", 64'({cout, overflow, zero, busy, done}), 64'd0);

    // Reset wins over a simultaneous start
    start = 1'b1; op = 3'd2; a = 8'h12; b = 8'h34;
    tick();
    check("rst_prio.busy", 64'(busy), 64'd0);
    check("rst_prio.done", 64'(done), 64'd0);
    check("rst_prio.result", 64'(result), 64'd0);
    start = 1'b0; reset = 1'b0;
    tick();

    run_op("add_ff_01", 3'd2, 8'hFF, 8'h01);
    check("add_ff_01.const", 64'({result, cout, overflow, zero}), 64'({8'h00, 1'b1, 1'b0, 1'b1}));

    run_op("add_ovf", 3'd2, 8'h7F, 8'h01);
    check("add_ovf.const", 64'({result, overflow, cout}), 64'({8'h80, 1'b1, 1'b0}));
    run_op("slt_neg", 3'd7, 8'h80, 8'h01);
    check("slt_neg.const", 64'(result), 64'h01);

    run_op("mul_ff_ff", 3'd3, 8'hFF, 8'hFF);
    check("mul_ff_ff.const", 64'({result_hi, result, zero}), 64'({8'hFE, 8'h01, 1'b0}));

    // Start requests during MULT are ignored, not queued
    start = 1'b1; op = 3'd3; a = 8'hA5; b = 8'h3C;
    tick();
    op = 3'd2; a = 8'h01; b = 8'h01;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) pulses++;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick();
    end
    check("ignore.pulses", 64'(pulses), 64'd1);
    check_outputs("ignore", 3'd3, 8'hA5, 8'h3C);

    // Reset in the 4th MULT cycle aborts with no done pulse
    start = 1'b1; op = 3'd3; a = 8'hC3; b = 8'h77;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.outs", 64'({result_hi, result, cout, overflow, zero}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("abort.no_done", 64'(pulses), 64'd0);

    // Randomized single ops, including MUL
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
      if (i % 8 == 0) rb = ra;
      run_op($sformatf("rand%0d", i), ro, ra, rb);
    end

    // Back-to-back: start held high, alternating random non-MUL ops
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 6));
      if (ro == 3'd3) ro = 3'd7;
      if (i % 2 == 1) ro = (ro == 3'd2) ? 3'd6 : 3'd2;
      ra = $urandom; rb = $urandom;
      op = ro; a = ra; b = rb;
      tick();
      check($sformatf("b2b%0d.done", i), 64'(done), 64'd1);
      check_outputs($sformatf("b2b%0d", i), ro, ra, rb);
      tick();
      check($sformatf("b2b%0d.gap", i), 64'({busy, done}), 64'd0);
    end
    start = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
